// File: rtl/alu_mc_nbit.sv
// Multi-cycle, width-parametrised ALU with valid/ready handshakes on both sides,
// registered results and flags, and an iterative shift-add unsigned multiplier.
module alu_mc_nbit #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALU_Sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic [WIDTH-1:0] Out_hi,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero,
  output logic             Neg
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_SHL = 3'b111;

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic [SHW-1:0]     cnt;

  logic [WIDTH:0]     add_w, sub_w, shr_w, shl_w;
  logic [WIDTH-1:0]   res;
  logic               res_c, res_v;
  logic [WIDTH:0]     step_sum;
  logic [2*WIDTH-1:0] prod_next;

  // Single-cycle ops; the extra bit of each shift carries the last bit shifted out.
  always_comb begin
    add_w = {1'b0, A} + {1'b0, B};
    sub_w = {1'b0, A} - {1'b0, B};
    shr_w = {A, 1'b0} >> B[SHW-1:0];
    shl_w = {1'b0, A} << B[SHW-1:0];
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (ALU_Sel)
      OP_ADD: begin
        res   = add_w[WIDTH-1:0];
        res_c = add_w[WIDTH];
        res_v = (A[WIDTH-1] == B[WIDTH-1]) && (add_w[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        res   = sub_w[WIDTH-1:0];
        res_c = sub_w[WIDTH];
        res_v = (A[WIDTH-1] != B[WIDTH-1]) && (sub_w[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND: res = A & B;
      OP_OR:  res = A | B;
      OP_XOR: res = A ^ B;
      OP_SHR: begin
        res   = shr_w[WIDTH:1];
        res_c = shr_w[0];
      end
      OP_SHL: begin
        res   = shl_w[WIDTH-1:0];
        res_c = shl_w[WIDTH];
      end
      default: ;
    endcase
  end

  // One shift-add step: multiplier sits in the low half and is consumed LSB first.
  always_comb begin
    step_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_next = {step_sum, prod[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      Out       <= '0;
      Out_hi    <= '0;
      Cout      <= 1'b0;
      Ovf       <= 1'b0;
      Zero      <= 1'b0;
      Neg       <= 1'b0;
      mcand     <= '0;
      prod      <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (ALU_Sel == OP_MUL) begin
              mcand <= A;
              prod  <= {{WIDTH{1'b0}}, B};
              cnt   <= '0;
              state <= MUL;
            end else begin
              Out       <= res;
              Out_hi    <= '0;
              Cout      <= res_c;
              Ovf       <= res_v;
              Zero      <= (res == '0);
              Neg       <= res[WIDTH-1];
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        MUL: begin
          prod <= prod_next;
          cnt  <= cnt + 1'b1;
          // The final step writes the finished product straight into the outputs.
          if (cnt == SHW'(WIDTH - 1)) begin
            Out       <= prod_next[WIDTH-1:0];
            Out_hi    <= prod_next[2*WIDTH-1:WIDTH];
            Cout      <= |prod_next[2*WIDTH-1:WIDTH];
            Ovf       <= 1'b0;
            Zero      <= (prod_next == '0);
            Neg       <= prod_next[WIDTH-1];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc_nbit.sv
// Scoreboard bench for alu_mc_nbit: directed vectors on an 8-bit and a 16-bit instance,
// expected results queued at issue and compared by per-instance output monitors.
module tb_alu_mc_nbit;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_SHL = 3'b111;

  typedef struct packed {
    logic [15:0] out;
    logic [15:0] hi;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;
  } exp_t;

  logic clk, rst;

  logic       iv8, ir8, ov8, ordy8;
  logic [7:0] a8, b8, o8, oh8;
  logic [2:0] s8;
  logic       c8, v8, z8, n8;

  logic        iv16, ir16, ov16, ordy16;
  logic [15:0] a16, b16, o16, oh16;
  logic [2:0]  s16;
  logic        c16, v16, z16, n16;

  int   checks = 0;
  int   errors = 0;
  exp_t q8[$];
  exp_t q16[$];
  exp_t e8, e16;
  int   lat;

  alu_mc_nbit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8), .ALU_Sel(s8),
    .out_valid(ov8), .out_ready(ordy8), .Out(o8), .Out_hi(oh8),
    .Cout(c8), .Ovf(v8), .Zero(z8), .Neg(n8)
  );

  alu_mc_nbit #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .A(a16), .B(b16), .ALU_Sel(s16),
    .out_valid(ov16), .out_ready(ordy16), .Out(o16), .Out_hi(oh16),
    .Cout(c16), .Ovf(v16), .Zero(z16), .Neg(n16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mkExp(input logic [15:0] out, input logic [15:0] hi,
                                 input logic cout, input logic ovf,
                                 input logic zero, input logic neg);
    exp_t e;
    e.out = out; e.hi = hi; e.cout = cout; e.ovf = ovf; e.zero = zero; e.neg = neg;
    return e;
  endfunction

  // Monitors pop one expectation per output handshake.
  always @(negedge clk) begin
    if (!rst && ov8 && ordy8) begin
      if (q8.size() == 0) begin
        checkOutput("w8 unexpected result", 32'd1, 32'd0);
      end else begin
        e8 = q8.pop_front();
        checkOutput("w8 Out",    {24'd0, o8},  {16'd0, e8.out});
        checkOutput("w8 Out_hi", {24'd0, oh8}, {16'd0, e8.hi});
        checkOutput("w8 Cout",   {31'd0, c8},  {31'd0, e8.cout});
        checkOutput("w8 Ovf",    {31'd0, v8},  {31'd0, e8.ovf});
        checkOutput("w8 Zero",   {31'd0, z8},  {31'd0, e8.zero});
        checkOutput("w8 Neg",    {31'd0, n8},  {31'd0, e8.neg});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ov16 && ordy16) begin
      if (q16.size() == 0) begin
        checkOutput("w16 unexpected result", 32'd1, 32'd0);
      end else begin
        e16 = q16.pop_front();
        checkOutput("w16 Out",    {16'd0, o16},  {16'd0, e16.out});
        checkOutput("w16 Out_hi", {16'd0, oh16}, {16'd0, e16.hi});
        checkOutput("w16 Cout",   {31'd0, c16},  {31'd0, e16.cout});
        checkOutput("w16 Ovf",    {31'd0, v16},  {31'd0, e16.ovf});
        checkOutput("w16 Zero",   {31'd0, z16},  {31'd0, e16.zero});
        checkOutput("w16 Neg",    {31'd0, n16},  {31'd0, e16.neg});
      end
    end
  end

  // Waits for in_ready, queues the expectation (when tracked) and holds in_valid for one edge.
  task automatic applyStimulus(input bit w16, input logic [2:0] op, input logic [15:0] a,
                               input logic [15:0] b, input exp_t e, input bit track);
    int g = 0;
    while (!(w16 ? ir16 : ir8) && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 200) checkOutput("in_ready wait timeout", 32'd0, 32'd1);
    if (track) begin
      if (w16) q16.push_back(e); else q8.push_back(e);
    end
    if (w16) begin
      a16 = a; b16 = b; s16 = op; iv16 = 1'b1;
    end else begin
      a8 = a[7:0]; b8 = b[7:0]; s8 = op; iv8 = 1'b1;
    end
    @(posedge clk); #1;
    iv8  = 1'b0;
    iv16 = 1'b0;
  endtask

  // Counts cycles from the accept edge to the first edge seeing out_valid.
  task automatic waitResult(input bit w16, output int l);
    l = 1;
    while (!(w16 ? ov16 : ov8) && l < 100) begin
      @(posedge clk); #1;
      l++;
    end
    if (l >= 100) checkOutput("out_valid wait timeout", 32'd0, 32'd1);
  endtask

  task automatic runOp(input bit w16, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input exp_t e, input int exp_lat, input string name);
    int l;
    applyStimulus(w16, op, a, b, e, 1'b1);
    waitResult(w16, l);
    checkOutput({name, " latency"}, l, exp_lat);
    @(posedge clk); #1;
    checkOutput({name, " out_valid drop"}, {31'd0, (w16 ? ov16 : ov8)}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    iv8 = 1'b0; a8 = '0; b8 = '0; s8 = '0; ordy8 = 1'b1;
    iv16 = 1'b0; a16 = '0; b16 = '0; s16 = '0; ordy16 = 1'b1;
    #12;
    checkOutput("reset in_ready",  {31'd0, ir8}, 32'd1);
    checkOutput("reset out_valid", {31'd0, ov8}, 32'd0);
    checkOutput("reset Out",       {24'd0, o8},  32'd0);
    checkOutput("reset Out_hi",    {24'd0, oh8}, 32'd0);
    checkOutput("reset flags",     {28'd0, c8, v8, z8, n8}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 8-bit arithmetic, logic and shift vectors
    runOp(0, OP_ADD, 16'd200,  16'd100,  mkExp(16'h2C, 0, 1, 0, 0, 0), 1, "add 200+100");
    runOp(0, OP_SUB, 16'd12,   16'd5,    mkExp(16'h07, 0, 0, 0, 0, 0), 1, "sub 12-5");
    runOp(0, OP_SUB, 16'd5,    16'd12,   mkExp(16'hF9, 0, 1, 0, 0, 1), 1, "sub 5-12");
    runOp(0, OP_SUB, 16'h80,   16'h01,   mkExp(16'h7F, 0, 0, 1, 0, 0), 1, "sub 80-01");
    runOp(0, OP_ADD, 16'h7F,   16'h01,   mkExp(16'h80, 0, 0, 1, 0, 1), 1, "add 7F+01");
    runOp(0, OP_MUL, 16'd12,   16'd5,    mkExp(16'h3C, 0, 0, 0, 0, 0), 9, "mul 12*5");
    runOp(0, OP_MUL, 16'd255,  16'd255,  mkExp(16'h01, 16'hFE, 1, 0, 0, 0), 9, "mul 255*255");
    runOp(0, OP_MUL, 16'h00,   16'h37,   mkExp(16'h00, 0, 0, 0, 1, 0), 9, "mul 0*37");
    runOp(0, OP_OR,  16'h00,   16'h00,   mkExp(16'h00, 0, 0, 0, 1, 0), 1, "or 0|0");
    runOp(0, OP_AND, 16'hF0,   16'h3C,   mkExp(16'h30, 0, 0, 0, 0, 0), 1, "and F0&3C");
    runOp(0, OP_SHR, 16'h0C,   16'h02,   mkExp(16'h03, 0, 0, 0, 0, 0), 1, "shr 0C>>2");
    runOp(0, OP_SHL, 16'h81,   16'h01,   mkExp(16'h02, 0, 1, 0, 0, 0), 1, "shl 81<<1");
    runOp(0, OP_SHL, 16'h81,   16'h09,   mkExp(16'h02, 0, 1, 0, 0, 0), 1, "shl amount bits");
    runOp(0, OP_SHR, 16'h81,   16'h00,   mkExp(16'h81, 0, 0, 0, 0, 1), 1, "shr by 0");

    // Backpressure: result held for 5 cycles while a second request is ignored
    ordy8 = 1'b0;
    applyStimulus(0, OP_ADD, 16'd3, 16'd4, mkExp(16'h07, 0, 0, 0, 0, 0), 1'b1);
    waitResult(0, lat);
    a8 = 8'hF0; b8 = 8'h3C; s8 = OP_AND; iv8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("bp Out stable",  {24'd0, o8},  32'h07);
      checkOutput("bp out_valid",   {31'd0, ov8}, 32'd1);
      checkOutput("bp in_ready",    {31'd0, ir8}, 32'd0);
    end
    ordy8 = 1'b1;
    q8.push_back(mkExp(16'h30, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    checkOutput("retire out_valid", {31'd0, ov8}, 32'd0);
    checkOutput("retire no accept", {31'd0, ir8}, 32'd1);
    @(posedge clk); #1;
    iv8 = 1'b0;
    checkOutput("accept after retire", {31'd0, ov8}, 32'd1);
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("no extra result", {31'd0, ov8}, 32'd0);

    // Asynchronous reset in the middle of a multiply discards it
    applyStimulus(0, OP_MUL, 16'd12, 16'd5, mkExp(16'h3C, 0, 0, 0, 0, 0), 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midmul rst out_valid", {31'd0, ov8}, 32'd0);
    checkOutput("midmul rst in_ready",  {31'd0, ir8}, 32'd1);
    checkOutput("midmul rst Out",       {24'd0, o8},  32'd0);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    runOp(0, OP_XOR, 16'hCC, 16'hAA, mkExp(16'h66, 0, 0, 0, 0, 0), 1, "xor after rst");

    // 16-bit corner cases
    runOp(1, OP_ADD, 16'hFFFF, 16'h0001, mkExp(16'h0000, 0, 1, 0, 1, 0), 1, "w16 add FFFF+1");
    runOp(1, OP_ADD, 16'h7FFF, 16'h0001, mkExp(16'h8000, 0, 0, 1, 0, 1), 1, "w16 add 7FFF+1");
    runOp(1, OP_MUL, 16'hFFFF, 16'hFFFF, mkExp(16'h0001, 16'hFFFE, 1, 0, 0, 0), 17, "w16 mul FFFF^2");
    runOp(1, OP_MUL, 16'h0100, 16'h0100, mkExp(16'h0000, 16'h0001, 1, 0, 0, 0), 17, "w16 mul 100^2");

    repeat (3) @(posedge clk);
    #1;
    checkOutput("w8 queue drained",  q8.size(),  32'd0);
    checkOutput("w16 queue drained", q16.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
